// File: rtl/narrow_to_wide.sv
// Narrow-to-wide packer: gathers OUT_DATA_ELS narrow beats into one wide line.
// The first beat of a line lands in the top element and later beats fill downwards.
// A line closes on its last element or on src_n_to_w_last, whichever comes first.
// On an early close, the unfilled lower elements carry zero data and zero keep.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   src_n_to_w_val/data/keep/last, n_to_w_src_rdy   narrow input stream
//   n_to_w_dst_val/data/keep/last, dst_n_to_w_rdy   wide output stream
module narrow_to_wide #(
  parameter int IN_DATA_W    = -1,
  parameter int IN_KEEP_W    = IN_DATA_W / 8,
  parameter int OUT_DATA_ELS = -1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   src_n_to_w_val,
  input  logic [IN_DATA_W-1:0]                   src_n_to_w_data,
  input  logic [IN_KEEP_W-1:0]                   src_n_to_w_keep,
  input  logic                                   src_n_to_w_last,
  output logic                                   n_to_w_src_rdy,
  output logic                                   n_to_w_dst_val,
  output logic [OUT_DATA_ELS-1:0][IN_DATA_W-1:0] n_to_w_dst_data,
  output logic [OUT_DATA_ELS-1:0][IN_KEEP_W-1:0] n_to_w_dst_keep,
  output logic                                   n_to_w_dst_last,
  input  logic                                   dst_n_to_w_rdy
);

  localparam int IdxW = $clog2(OUT_DATA_ELS);
  localparam logic [IdxW-1:0] IdxTop = IdxW'(OUT_DATA_ELS - 1);

  // Partial-line fill registers
  logic [OUT_DATA_ELS-1:0][IN_DATA_W-1:0] fill_data_q, fill_data_d;
  logic [OUT_DATA_ELS-1:0][IN_KEEP_W-1:0] fill_keep_q, fill_keep_d;
  logic [IdxW-1:0]                        idx_q, idx_d;

  // Output holding register
  logic [OUT_DATA_ELS-1:0][IN_DATA_W-1:0] out_data_q, out_data_d;
  logic [OUT_DATA_ELS-1:0][IN_KEEP_W-1:0] out_keep_q, out_keep_d;
  logic                                   out_last_q, out_last_d;
  logic                                   out_val_q, out_val_d;

  // Fill contents with the current beat merged in at the fill index
  logic [OUT_DATA_ELS-1:0][IN_DATA_W-1:0] line_data;
  logic [OUT_DATA_ELS-1:0][IN_KEEP_W-1:0] line_keep;

  logic beat_acc;
  logic line_done;

  // The holding register frees up in the same cycle it is consumed, so a new
  // line can load behind it with no bubble.
  assign n_to_w_src_rdy = !out_val_q || dst_n_to_w_rdy;
  assign beat_acc       = src_n_to_w_val && n_to_w_src_rdy;
  assign line_done      = beat_acc && ((idx_q == '0) || src_n_to_w_last);

  always_comb begin
    line_data        = fill_data_q;
    line_keep        = fill_keep_q;
    line_data[idx_q] = src_n_to_w_data;
    line_keep[idx_q] = src_n_to_w_keep;

    fill_data_d = fill_data_q;
    fill_keep_d = fill_keep_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_val_d   = out_val_q;

    if (out_val_q && dst_n_to_w_rdy) begin
      out_val_d = 1'b0;
    end

    if (beat_acc) begin
      if (line_done) begin
        out_data_d  = line_data;
        out_keep_d  = line_keep;
        out_last_d  = src_n_to_w_last;
        out_val_d   = 1'b1;
        // Clearing here means elements below an early close are already zero
        // for the next line, and no stale bytes can leak into it.
        fill_data_d = '0;
        fill_keep_d = '0;
        idx_d       = IdxTop;
      end else begin
        fill_data_d = line_data;
        fill_keep_d = line_keep;
        idx_d       = idx_q - IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_data_q <= '0;
      fill_keep_q <= '0;
      idx_q       <= IdxTop;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_val_q   <= 1'b0;
    end else begin
      fill_data_q <= fill_data_d;
      fill_keep_q <= fill_keep_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_val_q   <= out_val_d;
    end
  end

  assign n_to_w_dst_val  = out_val_q;
  assign n_to_w_dst_data = out_data_q;
  assign n_to_w_dst_keep = out_keep_q;
  assign n_to_w_dst_last = out_last_q;

endmodule

// File: tb/tb_narrow_to_wide.sv
// Self-checking bench for narrow_to_wide (64-bit beats, 4 elements per line).
// Packets are turned into expected lines by simple grouping arithmetic; observed
// lines are collected at each output handshake and compared in order.
module tb_narrow_to_wide;

  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int ELS = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [ELS-1:0][DW-1:0] data;
    logic [ELS-1:0][KW-1:0] keep;
    logic                   last;
  } line_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   src_val;
  logic [DW-1:0]          src_data;
  logic [KW-1:0]          src_keep;
  logic                   src_last;
  logic                   src_rdy;
  logic                   dst_val;
  logic [ELS-1:0][DW-1:0] dst_data;
  logic [ELS-1:0][KW-1:0] dst_keep;
  logic                   dst_last;
  logic                   dst_rdy;

  narrow_to_wide #(
    .IN_DATA_W    (DW),
    .IN_KEEP_W    (KW),
    .OUT_DATA_ELS (ELS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src_n_to_w_val  (src_val),
    .src_n_to_w_data (src_data),
    .src_n_to_w_keep (src_keep),
    .src_n_to_w_last (src_last),
    .n_to_w_src_rdy  (src_rdy),
    .n_to_w_dst_val  (dst_val),
    .n_to_w_dst_data (dst_data),
    .n_to_w_dst_keep (dst_keep),
    .n_to_w_dst_last (dst_last),
    .dst_n_to_w_rdy  (dst_rdy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t drv_q[$];
  line_t exp_q[$];
  line_t obs_q[$];
  int    val_pct = 100;
  int    rdy_pct = 100;
  int    proto_err = 0;
  int    rdy_low = 0;
  bit    hold_f = 1'b0;
  line_t held_l;

  // Build beats for one packet and the lines it must produce.
  task automatic add_packet(input int len, input logic [KW-1:0] last_keep);
    beat_t bs[$];
    beat_t b;
    line_t l;
    int    nl;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom(), $urandom()};
      b.keep = (i == len - 1) ? last_keep : 8'hFF;
      b.last = (i == len - 1);
      bs.push_back(b);
      drv_q.push_back(b);
    end
    nl = (len + ELS - 1) / ELS;
    for (int j = 0; j < nl; j++) begin
      l = '0;
      for (int e = 0; e < ELS; e++) begin
        if (j * ELS + e < len) begin
          l.data[ELS-1-e] = bs[j*ELS+e].data;
          l.keep[ELS-1-e] = bs[j*ELS+e].keep;
        end
      end
      l.last = (j == nl - 1);
      exp_q.push_back(l);
    end
  endtask

  // One clock: drive at the falling edge, observe handshakes, cross the rising edge.
  task automatic cycle();
    bit    acc;
    line_t o;
    if (drv_q.size() > 0 && $urandom_range(99) < val_pct) begin
      src_val  = 1'b1;
      src_data = drv_q[0].data;
      src_keep = drv_q[0].keep;
      src_last = drv_q[0].last;
    end else begin
      src_val  = 1'b0;
      src_data = {$urandom(), $urandom()};
      src_keep = KW'($urandom());
      src_last = 1'b0;
    end
    dst_rdy = ($urandom_range(99) < rdy_pct);
    #1;
    if (src_rdy !== (!dst_val || dst_rdy)) proto_err++;
    if (hold_f && (dst_val !== 1'b1 || dst_data !== held_l.data ||
                   dst_keep !== held_l.keep || dst_last !== held_l.last)) proto_err++;
    if (src_rdy !== 1'b1) rdy_low++;
    acc = src_val && src_rdy;
    o.data = dst_data;
    o.keep = dst_keep;
    o.last = dst_last;
    if (dst_val && dst_rdy) obs_q.push_back(o);
    hold_f = dst_val && !dst_rdy;
    held_l = o;
    @(posedge clk);
    if (acc) void'(drv_q.pop_front());
    @(negedge clk);
  endtask

  task automatic drain(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      if (drv_q.size() == 0 && obs_q.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic clear_model();
    drv_q.delete();
    exp_q.delete();
    obs_q.delete();
    proto_err = 0;
    rdy_low   = 0;
    hold_f    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; src_val = 1'b0; src_data = '0; src_keep = '0; src_last = 1'b0;
    dst_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dst_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b want 0", dst_val); end
    checks++;
    if (dst_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", dst_last); end
    checks++;
    if (dst_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", dst_data); end
    checks++;
    if (dst_keep !== '0) begin errors++; $display("FAIL reset_keep got %h want 0", dst_keep); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (src_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", src_rdy); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    clear_model();
    val_pct = 100; rdy_pct = 100;
    add_packet(8, 8'hFF);
    repeat (3) cycle();
    checks++;
    if (dst_val !== 1'b0) begin errors++; $display("FAIL basic_early_val got %b want 0", dst_val); end
    cycle();
    checks++;
    if (dst_val !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", dst_val); end
    drain(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got 0 want 1"); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_line %0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data,
                 obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    checks++;
    if (rdy_low !== 0) begin errors++; $display("FAIL basic_src_rdy got %0d low want 0", rdy_low); end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL basic_proto got %0d want 0", proto_err); end
  endtask

  task automatic test_partial();
    bit ok;
    clear_model();
    val_pct = 100; rdy_pct = 100;
    add_packet(3, 8'h0F);
    drain(50, ok);
    checks++;
    if (!ok || obs_q.size() !== 1) begin
      errors++; $display("FAIL partial_count got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL partial_line got %h/%h/%b want %h/%h/%b", obs_q[0].data, obs_q[0].keep,
                 obs_q[0].last, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
      end
      checks++;
      if (obs_q[0].keep !== 32'hFFFF0F00) begin
        errors++; $display("FAIL partial_keep got %h want ffff0f00", obs_q[0].keep);
      end
      checks++;
      if (obs_q[0].data[0] !== '0 || obs_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL partial_tail got %h/%b want 0/1", obs_q[0].data[0], obs_q[0].last);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_model();
    val_pct = 100; rdy_pct = 100;
    add_packet(1, 8'hFF);
    add_packet(4, 8'hFF);
    drain(50, ok);
    checks++;
    if (!ok || obs_q.size() !== 2) begin
      errors++; $display("FAIL single_count got %0d want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL single_line %0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data,
                   obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
        end
      end
      checks++;
      if (obs_q[0].keep !== 32'hFF000000 || obs_q[0].last !== 1'b1) begin
        errors++; $display("FAIL single_keep got %h/%b want ff000000/1", obs_q[0].keep,
                           obs_q[0].last);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_model();
    val_pct = 100; rdy_pct = 0;
    add_packet(8, 8'hFF);
    repeat (9) cycle();
    checks++;
    if (drv_q.size() !== 4) begin
      errors++; $display("FAIL bp_accepted got %0d pending want 4", drv_q.size());
    end
    checks++;
    if (rdy_low == 0) begin errors++; $display("FAIL bp_src_rdy got 0 low cycles want >0"); end
    rdy_pct = 100;
    drain(50, ok);
    checks++;
    if (!ok || obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_line %0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data,
                 obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL bp_proto got %0d want 0", proto_err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    // Held output line discarded by reset
    clear_model();
    val_pct = 100; rdy_pct = 0;
    add_packet(1, 8'hFF);
    for (int k = 0; k < 10 && dst_val !== 1'b1; k++) cycle();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (dst_val !== 1'b0 || dst_keep !== '0) begin
      errors++; $display("FAIL rstmid_held got %b/%h want 0/0", dst_val, dst_keep);
    end
    @(negedge clk);
    rst = 1'b1;
    // Partial line of two beats discarded by reset
    clear_model();
    rdy_pct = 100;
    add_packet(4, 8'hFF);
    for (int k = 0; k < 10 && drv_q.size() > 2; k++) cycle();
    checks++;
    if (drv_q.size() !== 2) begin
      errors++; $display("FAIL rstmid_fill got %0d pending want 2", drv_q.size());
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (dst_val !== 1'b0) begin errors++; $display("FAIL rstmid_val got %b want 0", dst_val); end
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    add_packet(1, 8'hFF);
    drain(50, ok);
    checks++;
    if (!ok || obs_q.size() !== 1) begin
      errors++; $display("FAIL rstmid_count got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0] || obs_q[0].keep !== 32'hFF000000) begin
        errors++;
        $display("FAIL rstmid_line got %h/%h/%b want %h/%h/%b", obs_q[0].data, obs_q[0].keep,
                 obs_q[0].last, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int bad;
    clear_model();
    for (int p = 0; p < 1000; p++) add_packet($urandom_range(1, 13), 8'($urandom_range(1, 255)));
    ok = 1'b0;
    for (int k = 0; k < 60000; k++) begin
      if (k % 64 == 0) begin
        val_pct = $urandom_range(30, 100);
        rdy_pct = $urandom_range(30, 100);
      end
      if (drv_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    rdy_pct = 100;
    if (ok) drain(50, ok);
    checks++;
    if (!ok || obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        if (bad < 5)
          $display("FAIL rand_line %0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].data,
                   obs_q[i].keep, obs_q[i].last, exp_q[i].data, exp_q[i].keep, exp_q[i].last);
        bad++;
      end
    end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL rand_proto got %0d want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
